// File: rtl/alu_pipe.sv
// Handshaked, registered ALU: add/sub/logic/shift/compare with a full flag set.
// Define ALU_MUL_EN to add an iterative WIDTH-cycle shift-add multiplier on op 10.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             out_err,
    output logic             dbg_state
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif

    // Handshake: an operation is taken when in_valid && in_ready, a result is
    // taken when out_valid && out_ready; in_ready never looks at in_valid.
    logic             live_q;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             err_q, err_d;

    logic             accept;
    logic             accept_alu;
    logic             deliver;

    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;

    always_comb begin
        sum     = '0;
        shamt   = b[SHW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, a} + {1'b0, b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // carry-out of a + ~b + 1 is the "no borrow" indication
                sum     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MUL_EN
            OP_MUL:  alu_res = '0;
`endif
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               is_mul;
    logic               mul_done;

    assign is_mul     = (op == OP_MUL);
    assign in_ready   = live_q && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept_alu = accept && !is_mul;
    assign dbg_state  = (state_q == ST_MUL);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mul_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    state_d  = ST_MUL;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_MUL: begin
                // one multiplier bit per cycle; the last step lands in the result register
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    mul_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign in_ready   = live_q && (!out_valid_q || out_ready);
    assign accept_alu = accept;
    assign dbg_state  = 1'b0;
`endif

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        err_d       = err_q;
        if (deliver) begin
            out_valid_d = 1'b0;
        end
        if (accept_alu) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            flag_c_d    = alu_c;
            flag_v_d    = alu_v;
            flag_z_d    = (alu_res == '0);
            flag_n_d    = alu_res[WIDTH-1];
            err_d       = alu_err;
        end
`ifdef ALU_MUL_EN
        if (mul_done) begin
            out_valid_d = 1'b1;
            result_d    = acc_d[WIDTH-1:0];
            flag_c_d    = |acc_d[2*WIDTH-1:WIDTH];
            flag_v_d    = 1'b0;
            flag_z_d    = (acc_d[WIDTH-1:0] == '0);
            flag_n_d    = acc_d[WIDTH-1];
            err_d       = 1'b0;
        end
`endif
    end

    // live_q keeps in_ready low while reset is applied and releases it one edge later
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            live_q      <= 1'b1;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign out_err   = err_q;

endmodule
